fifo_flush_unpack: RTL
======================

# fifo_flush_unpack

Downstream consumer of the flush FIFO's 32-bit flush word. Accepts one packed word (eight 4-bit lanes, lane 0 in bits [3:0]) plus a valid-nibble count, then serialises the valid nibbles one per cycle over a valid/ready stream. It checks that the unused lanes carry the pad nibble and keeps saturating word and nibble counters for debug.

## Interface
Parameters:
- PAD_NIB, 4'hC, expected value of every lane at index >= count
- CNT_W, 16, width of the saturating statistics counters

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- word_valid_i  in  1  flush word offered
- word_data_i  in  32  packed nibbles; lane k = bits [4k+3:4k]
- word_cnt_i  in  4  number of valid lanes, 0..8
- word_ready_o  out  1  block can accept a word this cycle
- nib_valid_o  out  1  nib_data_o is valid
- nib_data_o  out  4  current nibble
- nib_last_o  out  1  current nibble is the last of its word
- nib_ready_i  in  1  sink accepts the nibble
- pad_err_o  out  1  sticky: an accepted word had a non-PAD lane at index >= count
- cnt_err_o  out  1  sticky: an accepted word had word_cnt_i > 8
- words_o  out  CNT_W  accepted words, saturating
- nibs_o  out  CNT_W  emitted nibbles, saturating

## Operation
- Word transfer: word_valid_i && word_ready_o at a posedge. Nibble transfer: nib_valid_o && nib_ready_i at a posedge.
- States: IDLE (no word held) and DRAIN (word held, nib_valid_o = 1).
- Holding registers: data[31:0], remaining count rem[3:0], lane index idx[2:0].
- word_ready_o = (state == IDLE) || (nib_valid_o && nib_ready_i && nib_last_o). This is combinational and allows back-to-back words with no bubble.
- On word transfer:
  - eff = min(word_cnt_i, 8). If word_cnt_i > 8, set cnt_err_o.
  - Check lanes eff..7 against PAD_NIB. Any mismatch sets pad_err_o.
  - Increment words_o.
  - If eff == 0: the word is consumed and nothing is emitted. Go to or stay in IDLE, unless a new word is loaded the same cycle.
  - Otherwise: load data, rem = eff, idx = 0, go to DRAIN.
- In DRAIN:
  - nib_data_o = data[4*idx +: 4].
  - nib_last_o = (rem == 1).
- On nibble transfer:
  - Increment nibs_o.
  - If not last: idx++ and rem--.
  - If last: accept a new word in the same cycle if offered, else go to IDLE.
- Backpressure: while nib_ready_i = 0, nib_data_o, nib_last_o, idx and rem hold stable.
- Counters saturate at all-ones and never wrap.
- Sticky flags clear only on reset.

## Timing
- Reset (synchronous, same posedge):
  - state = IDLE
  - nib_valid_o = 0, nib_data_o = 0, nib_last_o = 0
  - word_ready_o = 1
  - pad_err_o = 0, cnt_err_o = 0
  - words_o = 0, nibs_o = 0
  - data, idx, rem = 0
- Reset asserted mid-DRAIN discards the held word with no further nibbles. A word offered in the reset cycle is not accepted and is not counted.
- Latency: word accepted at edge N means nibble 0 is valid in cycle N+1 (registered output).
- Throughput: one nibble per cycle. A word with count c occupies the output for exactly c cycles with nib_ready_i held high.
- Simultaneous last-nibble transfer and word transfer at edge M: the new word's nibble 0 is valid in cycle M+1 with no gap.
- A count-0 word accepted while IDLE leaves nib_valid_o = 0. Consecutive count-0 words are accepted one per cycle.
- Error flags and counters update on the posedge of the triggering transfer and are visible in the next cycle.
- nib_valid_o never deasserts without a nibble transfer, except on reset.

## Test plan
- After reset: word 32'hCCCC_4321 with count 4, sink always ready -> nibbles 1,2,3,4 on cycles N+1..N+4; last only with 4; words_o = 1, nibs_o = 4; no error flags.
- Back-to-back: word 32'h8765_4321 (count 8) then 32'hCCCC_CCBA (count 2), offered continuously -> 10 consecutive valid cycles: 1..8, A, B; word_ready_o high during the cycle of nibble 8.
- Backpressure: count 3, word 32'hCCCC_C9F5; nib_ready_i low for 3 cycles after the first nibble -> nibble F held stable, then 9; nibs_o = 3.
- Errors: 32'hCCCC_D321 with count 3 -> pad_err_o = 1 and stays 1 through later clean words. Count 4'hA with 32'hFFFF_FFFF -> 8 nibbles F emitted, cnt_err_o = 1.
- Count 0 with 32'hCCCC_CCCC -> no nib_valid_o, words_o increments; then 32'h1234_5678 with count 8 -> nibbles 8,7,6,5,4,3,2,1.
- Reset asserted on the 2nd nibble of a count-5 word -> next cycle nib_valid_o = 0, word_ready_o = 1, all counters and flags 0.

Source files
------------

// File: rtl/fifo_flush_unpack_if.sv
// Word-in / nibble-out stream bundle for the flush word unpacker.
// The slave modport is the unpacker's view; master is the driver/sink side.
interface fifo_flush_unpack_if;
    logic        word_valid_i;
    logic [31:0] word_data_i;
    logic [3:0]  word_cnt_i;
    logic        word_ready_o;
    logic        nib_valid_o;
    logic [3:0]  nib_data_o;
    logic        nib_last_o;
    logic        nib_ready_i;

    modport slave (
        input  word_valid_i, word_data_i, word_cnt_i, nib_ready_i,
        output word_ready_o, nib_valid_o, nib_data_o, nib_last_o
    );

    modport master (
        output word_valid_i, word_data_i, word_cnt_i, nib_ready_i,
        input  word_ready_o, nib_valid_o, nib_data_o, nib_last_o
    );
endinterface

// File: rtl/fifo_flush_unpack.sv
// Serialises the valid nibbles of a packed 32-bit flush word, checks the pad
// lanes and keeps saturating word/nibble debug counters.
module fifo_flush_unpack #(
    parameter logic [3:0]  PAD_NIB = 4'hC,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_flush_unpack_if.slave   bus,
    output logic                 pad_err_o,
    output logic                 cnt_err_o,
    output logic [CNT_W-1:0]     words_o,
    output logic [CNT_W-1:0]     nibs_o
);
    localparam int unsigned LANES = 8;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [31:0]        data_q, data_d;
    logic [3:0]         rem_q, rem_d;
    logic [2:0]         idx_q, idx_d;
    logic               pad_q, pad_d;
    logic               cerr_q, cerr_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic [CNT_W-1:0]   nibs_q, nibs_d;

    logic               nib_valid, nib_last, nib_xfer, word_ready, word_xfer, pad_bad;
    logic [3:0]         nib_data, eff;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            pad_q   <= 1'b0;
            cerr_q  <= 1'b0;
            words_q <= '0;
            nibs_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            pad_q   <= pad_d;
            cerr_q  <= cerr_d;
            words_q <= words_d;
            nibs_q  <= nibs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        pad_d   = pad_q;
        cerr_d  = cerr_q;
        words_d = words_q;
        nibs_d  = nibs_q;

        nib_valid  = (state_q == DRAIN);
        nib_last   = nib_valid && (rem_q == 4'd1);
        nib_data   = nib_valid ? data_q[{idx_q, 2'b00} +: 4] : 4'd0;
        nib_xfer   = nib_valid && bus.nib_ready_i;
        // Ready on the last-nibble handoff so words stream without a bubble.
        word_ready = !nib_valid || (nib_xfer && nib_last);
        word_xfer  = bus.word_valid_i && word_ready;
        eff        = (bus.word_cnt_i > 4'd8) ? 4'd8 : bus.word_cnt_i;

        pad_bad = 1'b0;
        for (int k = 0; k < int'(LANES); k++) begin
            if ((4'(k) >= eff) && (bus.word_data_i[4*k +: 4] != PAD_NIB)) begin
                pad_bad = 1'b1;
            end
        end

        if (nib_xfer) begin
            if (nibs_q != {CNT_W{1'b1}}) nibs_d = nibs_q + CNT_W'(1);
            if (nib_last) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q + 3'd1;
                rem_d = rem_q - 4'd1;
            end
        end

        // A count-0 word is only counted and checked; state stays as set above.
        if (word_xfer) begin
            if (words_q != {CNT_W{1'b1}}) words_d = words_q + CNT_W'(1);
            if (bus.word_cnt_i > 4'd8) cerr_d = 1'b1;
            if (pad_bad) pad_d = 1'b1;
            if (eff != 4'd0) begin
                state_d = DRAIN;
                data_d  = bus.word_data_i;
                rem_d   = eff;
                idx_d   = 3'd0;
            end
        end
    end

    assign bus.word_ready_o = word_ready;
    assign bus.nib_valid_o  = nib_valid;
    assign bus.nib_data_o   = nib_data;
    assign bus.nib_last_o   = nib_last;
    assign pad_err_o        = pad_q;
    assign cnt_err_o        = cerr_q;
    assign words_o          = words_q;
    assign nibs_o           = nibs_q;
endmodule
